multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_decode.sv | 106 ++++++++++
 rtl/multicycle_control.sv | 94 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALU-op and state definitions for the multicycle MIPS controller.
// Defining MC_JAL_LINK_EN adds the JALWB link-write state.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0111;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_ORI   = 4'b0101;
    localparam logic [3:0] ALU_ANDI  = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b1000;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP
`ifdef MC_JAL_LINK_EN
        , JALWB
`endif
    } state_t;

    // DECODE dispatch target; FETCH here means the opcode is illegal.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                     return MEMADR;
            OP_RTYPE:                         return EXEC_R;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return EXEC_I;
            OP_BEQ, OP_BNE:                   return BRANCH;
            OP_J:                             return JUMP;
`ifdef MC_JAL_LINK_EN
            OP_JAL:                           return JALWB;
`else
            OP_JAL:                           return JUMP;
`endif
            default:                          return FETCH;
        endcase
    endfunction

    function automatic logic [3:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_ORI;
            OP_ANDI: return ALU_ANDI;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decode for multicycle_control.
// Builds the JALWB outputs only when MC_JAL_LINK_EN is defined.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_op,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    input  logic        i_timeout,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_a,
    output logic [1:0]  o_reg_dst,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_pc_source,
    output logic [3:0]  o_alu_op,
    output logic        o_illegal_op
);

    always_comb begin
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_reg_dst    = 2'b00;
        o_alu_src_b  = 2'b00;
        o_pc_source  = 2'b00;
        o_alu_op     = 4'b0000;
        o_illegal_op = 1'b0;
        case (i_state)
            FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_alu_op    = ALU_ADD;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_b  = 2'b11;
                o_alu_op     = ALU_ADD;
                o_illegal_op = (dispatch(i_op) == FETCH);
            end
            MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_op    = ALU_ADD;
            end
            MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            // A timed-out store must not reach memory.
            MEMWR: begin
                o_mem_write = ~i_timeout;
                o_iord      = 1'b1;
            end
            EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_RTYPE;
            end
            EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_op    = immAluOp(i_op);
            end
            ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = (i_op == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_SUB;
                o_pc_source = 2'b01;
                o_pc_write  = (i_op == OP_BNE) ? ~i_zero : i_zero;
            end
            JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = 2'b10;
            end
`ifdef MC_JAL_LINK_EN
            JALWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 2'b10;
                o_pc_write  = 1'b1;
                o_pc_source = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, memory wait counter and next-state logic.
// MC_JAL_LINK_EN selects a linking jal (JALWB) instead of a plain jump.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  reg_dst,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [3:0]  alu_op,
    output logic        illegal_op,
    output logic        mem_timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_waitCnt;
    logic               r_armed;
    logic               w_waitState;
    logic               w_timeout;

    assign w_waitState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout   = w_waitState && !mem_ready && (r_waitCnt == CNT_W'(MEM_TIMEOUT));
    assign mem_timeout = w_timeout;

    // r_armed delays leaving IDLE by one edge so FETCH starts on the second edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_armed <= 1'b1;
            if (w_nextState != r_state || w_timeout || !w_waitState)
                r_waitCnt <= '0;
            else
                r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = r_armed ? FETCH : IDLE;
            FETCH:   w_nextState = mem_ready ? DECODE : FETCH;
            DECODE:  w_nextState = dispatch(op);
            MEMADR:  w_nextState = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_nextState = mem_ready ? MEMWB : (w_timeout ? FETCH : MEMRD);
            MEMWR:   w_nextState = (mem_ready || w_timeout) ? FETCH : MEMWR;
            EXEC_R:  w_nextState = ALUWB;
            EXEC_I:  w_nextState = ALUWB;
            default: w_nextState = FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state      (r_state),
        .i_op         (op),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .i_timeout    (w_timeout),
        .o_iord       (iord),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_ir_write   (ir_write),
        .o_pc_write   (pc_write),
        .o_reg_write  (reg_write),
        .o_mem_to_reg (mem_to_reg),
        .o_alu_src_a  (alu_src_a),
        .o_reg_dst    (reg_dst),
        .o_alu_src_b  (alu_src_b),
        .o_pc_source  (pc_source),
        .o_alu_op     (alu_op),
        .o_illegal_op (illegal_op)
    );

endmodule
